// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: mul/div op codes, FSM state encodings and decode helpers.
package mips_pkg;

  localparam int MD_NB_OP = 2;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input logic [MD_NB_OP-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/seg_execute_muldiv_if.sv
// Pipeline <-> mul/div unit bundle: request, MTHI/MTLO writes, status and HI/LO read-out.
interface seg_execute_muldiv_if #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 2
);
  logic               start;
  logic [NB_OP-1:0]   op;
  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic               flush;
  logic               wr_hi;
  logic               wr_lo;
  logic [NB_DATA-1:0] wr_data;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [NB_DATA-1:0] hi;
  logic [NB_DATA-1:0] lo;

  modport master (
    output start, op, data_a, data_b, flush, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, data_a, data_b, flush, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/seg_execute_muldiv_signfix.sv
// Sign handling for the mul/div core: operand magnitudes on the way in, result
// sign correction (product, quotient, remainder) on the way out.
module seg_execute_muldiv_signfix #(
  parameter int NB_DATA = 32
) (
  input  logic               i_signed,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  output logic [NB_DATA-1:0] o_a_mag,
  output logic [NB_DATA-1:0] o_b_mag,
  output logic               o_a_neg,
  output logic               o_b_neg,
  input  logic               i_res_div,
  input  logic               i_res_a_neg,
  input  logic               i_res_b_neg,
  input  logic [NB_DATA-1:0] i_hi,
  input  logic [NB_DATA-1:0] i_lo,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);
  logic [2*NB_DATA-1:0] prod_neg;

  always_comb begin
    o_a_neg  = i_signed & i_a[NB_DATA-1];
    o_b_neg  = i_signed & i_b[NB_DATA-1];
    // MIN stays MIN; read as unsigned it is already the right magnitude
    o_a_mag  = o_a_neg ? -i_a : i_a;
    o_b_mag  = o_b_neg ? -i_b : i_b;
    prod_neg = -{i_hi, i_lo};
    o_hi     = i_hi;
    o_lo     = i_lo;
    if (i_res_div) begin
      if (i_res_a_neg ^ i_res_b_neg) o_lo = -i_lo;
      if (i_res_a_neg)               o_hi = -i_hi;
    end else if (i_res_a_neg ^ i_res_b_neg) begin
      {o_hi, o_lo} = prod_neg;
    end
  end
endmodule

// File: rtl/seg_execute_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one bit per cycle.
// Signed ops are enabled by defining MULDIV_SIGNED_EN; otherwise every op is unsigned.
module seg_execute_muldiv
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  seg_execute_muldiv_if.slave  mdif
);
  localparam int NB_CNT  = $clog2(NB_DATA) + 1;
  localparam int NB_PROD = 2 * NB_DATA;
  localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_DATA - 1);

  md_state_e           state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_PROD-1:0]  work_q, work_d;
  logic [NB_DATA-1:0]  opb_q, opb_d;
  logic                is_div_q, is_div_d;
  logic [NB_DATA-1:0]  hi_q, hi_d;
  logic [NB_DATA-1:0]  lo_q, lo_d;
  logic                dbz_q, dbz_d;

  logic [NB_DATA-1:0]  a_mag, b_mag;
  logic [NB_DATA-1:0]  res_hi, res_lo;
  logic [NB_PROD-1:0]  step;
  logic [NB_DATA:0]    add_sum;
  logic [NB_DATA:0]    shifted;
  logic [NB_DATA:0]    sub_diff;

  // work_q holds {partial product | multiplier} or {remainder | dividend/quotient};
  // opb_q holds the multiplicand or divisor magnitude.
  always_comb begin
    add_sum  = {1'b0, work_q[NB_PROD-1:NB_DATA]} + (work_q[0] ? {1'b0, opb_q} : '0);
    shifted  = work_q[NB_PROD-1:NB_DATA-1];
    sub_diff = shifted - {1'b0, opb_q};
    if (is_div_q) begin
      if (!sub_diff[NB_DATA]) step = {sub_diff[NB_DATA-1:0], work_q[NB_DATA-2:0], 1'b1};
      else                    step = {shifted[NB_DATA-1:0],  work_q[NB_DATA-2:0], 1'b0};
    end else begin
      step = {add_sum, work_q[NB_DATA-1:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic a_neg_q, a_neg_d;
  logic b_neg_q, b_neg_d;

  seg_execute_muldiv_signfix #(.NB_DATA(NB_DATA)) u_signfix (
    .i_signed    (!mdif.op[0]),
    .i_a         (mdif.data_a),
    .i_b         (mdif.data_b),
    .o_a_mag     (a_mag),
    .o_b_mag     (b_mag),
    .o_a_neg     (a_neg),
    .o_b_neg     (b_neg),
    .i_res_div   (is_div_q),
    .i_res_a_neg (a_neg_q),
    .i_res_b_neg (b_neg_q),
    .i_hi        (step[NB_PROD-1:NB_DATA]),
    .i_lo        (step[NB_DATA-1:0]),
    .o_hi        (res_hi),
    .o_lo        (res_lo)
  );

  // Signs are tracked every idle cycle so the accepting cycle's values are kept
  always_comb begin
    a_neg_d = (state_q == MD_IDLE) ? a_neg : a_neg_q;
    b_neg_d = (state_q == MD_IDLE) ? b_neg : b_neg_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else begin
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
    end
  end
`else
  assign a_mag  = mdif.data_a;
  assign b_mag  = mdif.data_b;
  assign res_hi = step[NB_PROD-1:NB_DATA];
  assign res_lo = step[NB_DATA-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    case (state_q)
      MD_IDLE: begin
        if (mdif.wr_hi) hi_d = mdif.wr_data;
        if (mdif.wr_lo) lo_d = mdif.wr_data;
        if (mdif.start && !mdif.flush) begin
          is_div_d = md_is_div(mdif.op);
          cnt_d    = '0;
          dbz_d    = 1'b0;
          opb_d    = is_div_d ? b_mag : a_mag;
          work_d   = {{NB_DATA{1'b0}}, (is_div_d ? a_mag : b_mag)};
          if (is_div_d && (mdif.data_b == '0)) begin
            // Result write overrides any MTHI/MTLO in the same cycle
            state_d = MD_DONE;
            hi_d    = mdif.data_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (mdif.flush) begin
          state_d = MD_IDLE;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + NB_CNT'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = MD_DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign mdif.busy        = (state_q == MD_CALC);
  assign mdif.done        = (state_q == MD_DONE);
  assign mdif.div_by_zero = dbz_q;
  assign mdif.hi          = hi_q;
  assign mdif.lo          = lo_q;

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// Self-checking bench for seg_execute_muldiv: directed vector table, control corner
// sequences, and random ops against a plain-arithmetic reference model.
module tb_seg_execute_muldiv;
  import mips_pkg::*;

  localparam int NB_DATA = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seg_execute_muldiv_if #(.NB_DATA(NB_DATA), .NB_OP(2)) mdif ();

  seg_execute_muldiv #(.NB_DATA(NB_DATA), .NB_OP(2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .mdif    (mdif.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics straight from integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    bit          sgn;
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    sgn = SIGNED_EN && !op[0];
    dbz = 1'b0;
    if (!op[1]) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dbz = 1'b1;
    end else if (sgn) begin
      ia = $signed(a);
      ib = $signed(b);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'd0;
      end else begin
        lo = 32'(ia / ib);
        hi = 32'(ia % ib);
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    mdif.start  = 1'b1;
    mdif.op     = op;
    mdif.data_a = a;
    mdif.data_b = b;
    @(negedge clk);
    mdif.start  = 1'b0;
  endtask

  // Returns at the negedge where o_done is seen (or the bound expired)
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 1;
    busy_cnt = 0;
    while (!mdif.done && cyc < 200) begin
      if (mdif.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (!mdif.done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no o_done after %0d cycles, expected pulse", cyc);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                               input logic edbz, input int ecyc);
    int cyc, busy_cnt;
    issue(op, a, b);
    wait_done(cyc, busy_cnt);
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b cyc=%0d", tag, op, a, b,
             mdif.hi, mdif.lo, mdif.div_by_zero, cyc);
    check({tag, "_hi"},   mdif.hi, ehi);
    check({tag, "_lo"},   mdif.lo, elo);
    check({tag, "_dbz"},  32'(mdif.div_by_zero), 32'(edbz));
    check({tag, "_cyc"},  32'(cyc), 32'(ecyc));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(ecyc - 1));
    @(negedge clk);
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] val);
    if (to_hi) mdif.wr_hi = 1'b1;
    else       mdif.wr_lo = 1'b1;
    mdif.wr_data = val;
    @(negedge clk);
    mdif.wr_hi = 1'b0;
    mdif.wr_lo = 1'b0;
  endtask

  vec_t        vecs[11];
  logic [31:0] corners[5];

  initial begin
    int          cyc, done_seen;
    logic [31:0] ehi, elo, ra, rb;
    logic        edbz;
    logic [1:0]  rop;

    mdif.start = 1'b0; mdif.op = 2'b00; mdif.data_a = '0; mdif.data_b = '0;
    mdif.flush = 1'b0; mdif.wr_hi = 1'b0; mdif.wr_lo = 1'b0; mdif.wr_data = '0;

    vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 1'b0, 33};
    vecs[1]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5, SIGNED_EN ? 32'hFFFF_FFFF : 32'h4, 32'hFFFF_FFF1, 1'b0, 33};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2, SIGNED_EN ? 32'hFFFF_FFFF : 32'h1,
                 SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0, 33};
    vecs[3]  = '{MD_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, SIGNED_EN ? 32'h0 : 32'h8000_0000,
                 SIGNED_EN ? 32'h8000_0000 : 32'h0, 1'b0, 33};
    vecs[5]  = '{MD_MULT,  32'hFFFF_FFFF, 32'd2, SIGNED_EN ? 32'hFFFF_FFFF : 32'h1, 32'hFFFF_FFFE, 1'b0, 33};
    vecs[6]  = '{MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
    vecs[7]  = '{MD_DIV,   32'd7, 32'hFFFF_FFFE, SIGNED_EN ? 32'h1 : 32'h7,
                 SIGNED_EN ? 32'hFFFF_FFFD : 32'h0, 1'b0, 33};
    vecs[8]  = '{MD_DIV,   32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33};
    vecs[10] = '{MD_MULTU, 32'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 33};

    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi", mdif.hi, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_lo",   mdif.lo, 32'h0);
    check("rst_busy", 32'(mdif.busy), 32'h0);
    check("rst_done", 32'(mdif.done), 32'h0);
    check("rst_dbz",  32'(mdif.div_by_zero), 32'h0);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].cyc);
    end

    // MTHI/MTLO in IDLE take effect on the next edge
    mt_write(1'b0, 32'h1234);
    $display("[TB] mtlo 1234 -> lo=%h", mdif.lo);
    check("mtlo_idle", mdif.lo, 32'h1234);
    mt_write(1'b1, 32'hAAAA_5555);
    $display("[TB] mthi aaaa5555 -> hi=%h", mdif.hi);
    check("mthi_idle", mdif.hi, 32'hAAAA_5555);

    // MTHI and a new start during CALC are both ignored
    issue(MD_MULTU, 32'd3, 32'd4);
    cyc = 1;
    while (!mdif.done && cyc < 200) begin
      if (cyc == 5) begin
        mdif.wr_hi = 1'b1; mdif.wr_data = 32'hDEAD_BEEF;
        mdif.start = 1'b1; mdif.op = MD_DIVU; mdif.data_a = 32'd100; mdif.data_b = 32'd0;
      end else if (cyc == 6) begin
        mdif.wr_hi = 1'b0;
        check("mthi_in_calc", mdif.hi, 32'hAAAA_5555);
        check("busy_in_calc", 32'(mdif.busy), 32'h1);
      end
      @(negedge clk);
      cyc++;
    end
    mdif.start = 1'b0;
    $display("[TB] multu 3*4 with stray start/mthi -> hi=%h lo=%h cyc=%0d", mdif.hi, mdif.lo, cyc);
    check("stray_cyc", 32'(cyc), 32'd33);
    check("stray_hi",  mdif.hi, 32'h0);
    check("stray_lo",  mdif.lo, 32'd12);
    check("stray_dbz", 32'(mdif.div_by_zero), 32'h0);
    @(negedge clk);
    check("stray_idle_busy", 32'(mdif.busy), 32'h0);
    check("stray_idle_done", 32'(mdif.done), 32'h0);

    // Flush at cycle 10 of DIVU: back to IDLE, no o_done, HI/LO untouched
    mt_write(1'b1, 32'h1111_1111);
    mt_write(1'b0, 32'h2222_2222);
    issue(MD_DIVU, 32'd1000, 32'd3);
    for (int c = 1; c < 10; c++) @(negedge clk);
    mdif.flush = 1'b1;
    @(negedge clk);
    mdif.flush = 1'b0;
    check("flush_busy", 32'(mdif.busy), 32'h0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (mdif.done) done_seen++;
      @(negedge clk);
    end
    $display("[TB] divu flushed at cycle 10 -> hi=%h lo=%h done_pulses=%0d", mdif.hi, mdif.lo, done_seen);
    check("flush_no_done", 32'(done_seen), 32'h0);
    check("flush_hi", mdif.hi, 32'h1111_1111);
    check("flush_lo", mdif.lo, 32'h2222_2222);

    // Start with flush in IDLE: request dropped
    mdif.flush = 1'b1;
    issue(MD_DIVU, 32'd5, 32'd0);
    mdif.flush = 1'b0;
    $display("[TB] start+flush in idle -> busy=%0b done=%0b", mdif.busy, mdif.done);
    check("sf_busy", 32'(mdif.busy), 32'h0);
    check("sf_done", 32'(mdif.done), 32'h0);
    check("sf_dbz",  32'(mdif.div_by_zero), 32'h0);
    check("sf_hi",   mdif.hi, 32'h1111_1111);

    // Async reset mid-CALC clears everything immediately
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    $display("[TB] reset mid-calc -> busy=%0b hi=%h lo=%h", mdif.busy, mdif.hi, mdif.lo);
    check("rmid_busy", 32'(mdif.busy), 32'h0);
    check("rmid_done", 32'(mdif.done), 32'h0);
    check("rmid_hi",   mdif.hi, 32'h0);
    check("rmid_lo",   mdif.lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rmid_after_busy", 32'(mdif.busy), 32'h0);

    // Randomized ops against the reference model
    for (int n = 0; n < 200; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 32'd0;
      if (rop[1] && $urandom_range(0, 1) == 1) rb = rb >> $urandom_range(8, 31);
      model(rop, ra, rb, ehi, elo, edbz);
      run_and_check($sformatf("rnd%0d", n), rop, ra, rb, ehi, elo, edbz, edbz ? 1 : 33);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion, expected $finish before 2000000");
    $fatal(1, "[TB] simulation time bound exceeded");
  end

endmodule
